// File: rtl/spi_memory_fsm.sv
// SPI slave transaction sequencer: counts conditioned SCLK edges, decodes the command
// frame and drives address latch, memory write, shift-register load and MISO enable.
module spi_memory_fsm #(
  parameter int unsigned FRAME_BITS = 8,
  parameter int unsigned READ_LAT   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs_n,
  input  logic       sclk_pe,
  input  logic       sclk_ne,
  input  logic       rw_bit,
  output logic       addr_we,
  output logic       dm_we,
  output logic       sr_we,
  output logic       miso_buff,
  output logic [3:0] bit_cnt
);

  typedef enum logic [3:0] {
    StIdle,
    StGet,
    StGot,
    StRdWait,
    StRdLoad,
    StRdSend,
    StWrGet,
    StWrCommit,
    StDone
  } state_e;

  localparam logic [3:0] FrameEnd = 4'(FRAME_BITS);
  localparam logic [7:0] LatEnd   = 8'(READ_LAT - 1);

  state_e     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] lat_q, lat_d;
  logic       addr_we_q, addr_we_d;
  logic       dm_we_q, dm_we_d;
  logic       sr_we_q, sr_we_d;
  logic       miso_buff_q, miso_buff_d;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    lat_d     = lat_q;

    unique case (state_q)
      StIdle: begin
        bit_cnt_d = 4'd0;
        if (!cs_n) state_d = StGet;
      end
      StGet: begin
        if (bit_cnt_q == FrameEnd) begin
          state_d   = StGot;
          bit_cnt_d = 4'd0;
        end else if (sclk_pe) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      StGot: begin
        bit_cnt_d = 4'd0;
        lat_d     = 8'd0;
        if (!rw_bit)            state_d = StWrGet;
        else if (READ_LAT == 0) state_d = StRdLoad;
        else                    state_d = StRdWait;
      end
      StRdWait: begin
        if (lat_q == LatEnd) state_d = StRdLoad;
        else                 lat_d   = lat_q + 8'd1;
      end
      StRdLoad: state_d = StRdSend;
      StRdSend: begin
        if (bit_cnt_q == FrameEnd) begin
          state_d   = StDone;
          bit_cnt_d = 4'd0;
        end else if (sclk_ne) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      StWrGet: begin
        if (bit_cnt_q == FrameEnd) begin
          state_d   = StWrCommit;
          bit_cnt_d = 4'd0;
        end else if (sclk_pe) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      StWrCommit: state_d = StDone;
      StDone: begin
        bit_cnt_d = 4'd0;
        if (cs_n) state_d = StIdle;
      end
      default: begin
        state_d   = StIdle;
        bit_cnt_d = 4'd0;
      end
    endcase

    // Chip-select release aborts everything, including a same-cycle edge or pending enable.
    if (state_q != StIdle && cs_n) begin
      state_d   = StIdle;
      bit_cnt_d = 4'd0;
    end

    addr_we_d   = (state_d == StGot);
    dm_we_d     = (state_d == StWrCommit);
    sr_we_d     = (state_d == StRdLoad);
    miso_buff_d = (state_d == StRdSend);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 4'd0;
      lat_q       <= 8'd0;
      addr_we_q   <= 1'b0;
      dm_we_q     <= 1'b0;
      sr_we_q     <= 1'b0;
      miso_buff_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      lat_q       <= lat_d;
      addr_we_q   <= addr_we_d;
      dm_we_q     <= dm_we_d;
      sr_we_q     <= sr_we_d;
      miso_buff_q <= miso_buff_d;
    end
  end

  assign addr_we   = addr_we_q;
  assign dm_we     = dm_we_q;
  assign sr_we     = sr_we_q;
  assign miso_buff = miso_buff_q;
  assign bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_spi_memory_fsm.sv
// Directed bench for spi_memory_fsm: write, read, abort, excess-edge and back-to-back cases.
module tb_spi_memory_fsm;

  logic       clk = 1'b0;
  logic       reset, cs_n, sclk_pe, sclk_ne, rw_bit;
  logic       addr_we, dm_we, sr_we, miso_buff;
  logic [3:0] bit_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Free-running pulse tallies; tests compare against a snapshot baseline.
  int n_addr = 0, n_dm = 0, n_sr = 0, n_miso = 0;
  int b_addr, b_dm, b_sr, b_miso;

  spi_memory_fsm #(
    .FRAME_BITS(8),
    .READ_LAT  (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cs_n     (cs_n),
    .sclk_pe  (sclk_pe),
    .sclk_ne  (sclk_ne),
    .rw_bit   (rw_bit),
    .addr_we  (addr_we),
    .dm_we    (dm_we),
    .sr_we    (sr_we),
    .miso_buff(miso_buff),
    .bit_cnt  (bit_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (addr_we)   n_addr++;
    if (dm_we)     n_dm++;
    if (sr_we)     n_sr++;
    if (miso_buff) n_miso++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b_addr = n_addr;
    b_dm   = n_dm;
    b_sr   = n_sr;
    b_miso = n_miso;
  endtask

  task automatic pe_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      sclk_pe = 1'b1;
      tick();
      sclk_pe = 1'b0;
      tick();
    end
  endtask

  task automatic ne_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      sclk_ne = 1'b1;
      tick();
      sclk_ne = 1'b0;
      tick();
    end
  endtask

  // Ends in DONE with cs_n still low.
  task automatic do_write();
    cs_n   = 1'b0;
    rw_bit = 1'b0;
    tick();
    pe_pulses(8);
    tick();
    pe_pulses(8);
    tick();
  endtask

  // Ends in DONE with cs_n still low.
  task automatic do_read();
    cs_n   = 1'b0;
    rw_bit = 1'b1;
    tick();
    pe_pulses(8);
    tick();
    tick();
    tick();
    ne_pulses(8);
  endtask

  initial begin
    // Reset with random inputs
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cs_n    = 1'($urandom);
      sclk_pe = 1'($urandom);
      sclk_ne = 1'($urandom);
      rw_bit  = 1'($urandom);
      tick();
    end
    check("rst_addr_we", addr_we, 0);
    check("rst_dm_we", dm_we, 0);
    check("rst_sr_we", sr_we, 0);
    check("rst_miso", miso_buff, 0);
    check("rst_bit_cnt", bit_cnt, 0);
    cs_n    = 1'b1;
    sclk_pe = 1'b0;
    sclk_ne = 1'b0;
    rw_bit  = 1'b0;
    reset   = 1'b0;
    tick();

    // Write transaction with cycle-exact checks around both frame ends
    snap();
    cs_n = 1'b0;
    tick();
    pe_pulses(7);
    check("wr_cmd_cnt7", bit_cnt, 7);
    sclk_pe = 1'b1;
    tick();
    sclk_pe = 1'b0;
    check("wr_cmd_cnt8", bit_cnt, 8);
    check("wr_no_addr_early", addr_we, 0);
    tick();
    check("wr_addr_we_got", addr_we, 1);
    check("wr_got_cnt0", bit_cnt, 0);
    tick();
    check("wr_addr_we_off", addr_we, 0);
    pe_pulses(7);
    sclk_pe = 1'b1;
    tick();
    sclk_pe = 1'b0;
    check("wr_data_cnt8", bit_cnt, 8);
    check("wr_dm_we_early", dm_we, 0);
    tick();
    check("wr_dm_we", dm_we, 1);
    tick();
    check("wr_dm_we_off", dm_we, 0);
    check("wr_done_cnt0", bit_cnt, 0);
    check("wr_n_addr", n_addr - b_addr, 1);
    check("wr_n_dm", n_dm - b_dm, 1);
    check("wr_n_sr", n_sr - b_sr, 0);
    check("wr_n_miso", n_miso - b_miso, 0);
    cs_n = 1'b1;
    tick();

    // Read transaction
    snap();
    cs_n   = 1'b0;
    rw_bit = 1'b1;
    tick();
    pe_pulses(8);
    check("rd_addr_we", addr_we, 1);
    tick();
    check("rd_wait_sr_we", sr_we, 0);
    check("rd_wait_addr_off", addr_we, 0);
    tick();
    check("rd_sr_we", sr_we, 1);
    check("rd_load_miso", miso_buff, 0);
    tick();
    check("rd_sr_we_off", sr_we, 0);
    check("rd_send_miso", miso_buff, 1);
    ne_pulses(7);
    sclk_ne = 1'b1;
    tick();
    sclk_ne = 1'b0;
    check("rd_send_cnt8", bit_cnt, 8);
    check("rd_send_miso_8", miso_buff, 1);
    tick();
    check("rd_done_miso", miso_buff, 0);
    check("rd_done_cnt0", bit_cnt, 0);
    check("rd_n_addr", n_addr - b_addr, 1);
    check("rd_n_sr", n_sr - b_sr, 1);
    check("rd_n_dm", n_dm - b_dm, 0);
    cs_n = 1'b1;
    tick();

    // Abort after 5th data-frame edge of a write
    snap();
    cs_n   = 1'b0;
    rw_bit = 1'b0;
    tick();
    pe_pulses(8);
    tick();
    pe_pulses(4);
    sclk_pe = 1'b1;
    tick();
    sclk_pe = 1'b0;
    check("ab_cnt5", bit_cnt, 5);
    cs_n = 1'b1;
    tick();
    check("ab_idle_cnt0", bit_cnt, 0);
    check("ab_dm_we", dm_we, 0);
    tick();
    tick();
    check("ab_n_dm", n_dm - b_dm, 0);

    // cs_n release coincident with the 8th command edge
    snap();
    cs_n = 1'b0;
    tick();
    pe_pulses(7);
    sclk_pe = 1'b1;
    cs_n    = 1'b1;
    tick();
    sclk_pe = 1'b0;
    check("ab8_cnt0", bit_cnt, 0);
    tick();
    tick();
    check("ab8_n_addr", n_addr - b_addr, 0);

    // Excess edges in DONE with cs_n held low
    do_write();
    snap();
    for (int i = 0; i < 10; i++) begin
      pe_pulses(1);
      check($sformatf("done_cnt_%0d", i), bit_cnt, 0);
    end
    check("done_n_addr", n_addr - b_addr, 0);
    check("done_n_dm", n_dm - b_dm, 0);
    check("done_n_sr", n_sr - b_sr, 0);
    check("done_n_miso", n_miso - b_miso, 0);
    cs_n = 1'b1;
    tick();

    // Reset mid-transaction with a full data frame pending
    cs_n   = 1'b0;
    rw_bit = 1'b0;
    tick();
    pe_pulses(8);
    tick();
    snap();
    pe_pulses(7);
    sclk_pe = 1'b1;
    tick();
    sclk_pe = 1'b0;
    reset   = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_cnt0", bit_cnt, 0);
    check("mrst_dm_we", dm_we, 0);
    cs_n = 1'b1;
    tick();
    tick();
    check("mrst_n_dm", n_dm - b_dm, 0);

    // Back-to-back write then read with a 2-clk cs_n gap
    snap();
    do_write();
    check("b2b_wr_n_addr", n_addr - b_addr, 1);
    check("b2b_wr_n_dm", n_dm - b_dm, 1);
    check("b2b_wr_n_sr", n_sr - b_sr, 0);
    cs_n = 1'b1;
    tick();
    tick();
    snap();
    do_read();
    check("b2b_rd_n_addr", n_addr - b_addr, 1);
    check("b2b_rd_n_sr", n_sr - b_sr, 1);
    check("b2b_rd_n_dm", n_dm - b_dm, 0);
    check("b2b_rd_miso_off", miso_buff, 0);
    cs_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
